// File: rtl/icache_controller.sv
`timescale 1ns/1ps
// icache_controller
// Direct-mapped instruction cache (8 lines x 16 bytes, 10-bit byte address)
// with a block-refill FSM towards a slow instruction memory. Hits are served
// combinationally; misses stall the CPU with busywait while the 16-byte block
// is fetched (IDLE -> MEM_READ -> UPDATE -> IDLE).
// Optional feature: define ICACHE_STATS_EN to build saturating hit/miss
// counters; otherwise hit_count and miss_count are tied to zero.
module icache_controller (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Line storage: valid is control (reset), tag/data are datapath (no reset).
  logic [7:0]   valid_q;
  logic [2:0]   tag_q  [8];
  logic [127:0] data_q [8];

  // Refill block captured in the data-valid MEM_READ cycle, committed in UPDATE.
  logic [127:0] blk_p0;

  logic [2:0] addr_tag;
  logic [2:0] idx;
  logic [1:0] off;
  logic       hit;
  logic       unused_addr_bits;

  assign addr_tag = address[9:7];
  assign idx      = address[6:4];
  assign off      = address[3:2];
  assign unused_addr_bits = ^address[1:0];

  assign hit = read & valid_q[idx] & (tag_q[idx] == addr_tag);

  // Word select from the indexed line; zero unless the current read hits.
  always_comb begin
    instruction = '0;
    if (hit) begin
      case (off)
        2'd0:    instruction = data_q[idx][31:0];
        2'd1:    instruction = data_q[idx][63:32];
        2'd2:    instruction = data_q[idx][95:64];
        default: instruction = data_q[idx][127:96];
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    case (state_q)
      IDLE: begin
        if (read && !hit) begin
          busywait = 1'b1;
          state_d  = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = {addr_tag, idx};
        busywait    = 1'b1;
        if (!mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        busywait = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid bits: cleared on reset, set when the refilled line commits.
  // A reset during MEM_READ or UPDATE therefore leaves the line invalid.
  always_ff @(posedge CLK) begin
    if (RESET)                 valid_q      <= '0;
    else if (state_q == UPDATE) valid_q[idx] <= 1'b1;
  end

  // ---- stage p0: capture memory block in the data-valid cycle ----
  always_ff @(posedge CLK) begin
    if (state_q == MEM_READ && !mem_busywait) blk_p0 <= mem_readdata;
  end

  // ---- line commit: data and tag written in UPDATE (conflicts overwrite) ----
  always_ff @(posedge CLK) begin
    if (state_q == UPDATE) begin
      data_q[idx] <= blk_p0;
      tag_q[idx]  <= addr_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic [9:0]  last_hit_addr_q;
  logic        last_hit_vld_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Hits count once per distinct address so stalled repeats are not double-counted;
  // misses count on each refill start.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      last_hit_addr_q <= '0;
      last_hit_vld_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && hit && (!last_hit_vld_q || address != last_hit_addr_q)) begin
        hit_cnt_q       <= sat_inc(hit_cnt_q);
        last_hit_addr_q <= address;
        last_hit_vld_q  <= 1'b1;
      end
      if (state_q == IDLE && state_d == MEM_READ) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_controller.sv
`timescale 1ns/1ps
// Testbench for icache_controller: directed scenarios followed by random
// fetch traffic, checked by a scoreboard fed from a tag-array reference model.
module tb_icache_controller;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         read = 1'b0;
  logic [9:0]   address = '0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b0;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  icache_controller dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction memory image and reference cache model (tags per index).
  logic [7:0] mem_img [1024];
  bit         mvalid [8];
  logic [2:0] mtag   [8];

  logic [31:0] exp_instr_q [$];
  logic [5:0]  exp_maddr_q [$];

  int next_lat = 1;
  int mem_cnt  = 0;
  bit prev_mr  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [9:0] a);
    int b;
    b = int'({a[9:2], 2'b00});
    return {mem_img[b+3], mem_img[b+2], mem_img[b+1], mem_img[b]};
  endfunction

  // Memory model: next_lat cycles of mem_read per block, data valid in the last one.
  always @(posedge CLK) begin
    #2;
    if (mem_read) begin
      mem_cnt++;
      if (mem_cnt < next_lat) begin
        mem_busywait = 1'b1;
        mem_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        mem_busywait = 1'b0;
        for (int i = 0; i < 16; i++)
          mem_readdata[8*i +: 8] = mem_img[int'(mem_address) * 16 + i];
      end
    end else begin
      mem_cnt      = 0;
      mem_busywait = 1'b0;
    end
  end

  // Monitor: pops expected words on accepted fetches and expected block
  // addresses whenever a memory request starts.
  always @(negedge CLK) begin
    if (read && !busywait) begin
      if (exp_instr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_fetch: got instruction %h, expected no accepted fetch", instruction);
      end else begin
        chk("instruction", instruction, exp_instr_q.pop_front());
      end
    end else begin
      chk("instruction_zero", instruction, 32'h0);
    end
    if (mem_read && !prev_mr) begin
      if (exp_maddr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_mem_read: got mem_address %h, expected no request", mem_address);
      end else begin
        chk("mem_address", 32'(mem_address), 32'(exp_maddr_q.pop_front()));
      end
    end
    prev_mr = mem_read;
  end

  // Issue one fetch starting just after a rising edge; returns just after the accepting edge.
  task automatic fetch(input logic [9:0] a, input int lat);
    logic [2:0] ix;
    bit exp_hit;
    bit done;
    int busy;
    int mrc;
    ix      = a[6:4];
    exp_hit = mvalid[ix] && (mtag[ix] == a[9:7]);
    read     = 1'b1;
    address  = a;
    next_lat = lat;
    exp_instr_q.push_back(ref_word(a));
    if (!exp_hit) exp_maddr_q.push_back(a[9:4]);
    busy = 0;
    mrc  = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge CLK);
      if (!busywait) done = 1'b1;
      else begin
        busy++;
        if (mem_read) mrc++;
        @(posedge CLK);
        #1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_timeout: got busywait stuck at address %h, expected release", a);
    end
    chk("stall_cycles", busy, exp_hit ? 0 : lat + 2);
    chk("mem_read_cycles", mrc, exp_hit ? 0 : lat);
    mvalid[ix] = 1'b1;
    mtag[ix]   = a[9:7];
    @(posedge CLK);
    #1;
    read = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    RESET = 1'b1;
    read  = 1'b0;
    address = '0;
    repeat (cycles) @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    @(negedge CLK);
    chk("reset_busywait", busywait, 0);
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_address", 32'(mem_address), 0);
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] ra;
    for (int i = 0; i < 1024; i++) mem_img[i] = 8'($urandom());
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = '0;
    end

    do_reset(2);

    // Cold miss with three-cycle memory, then hits within the block.
    fetch(10'h000, 3);
    fetch(10'h004, 1);
    fetch(10'h008, 2);
    fetch(10'h00C, 4);
`ifdef ICACHE_STATS_EN
    chk("miss_count_after_fill", miss_count, 1);
    chk("hit_count_after_fill", hit_count, 4);
`else
    chk("miss_count_disabled", miss_count, 0);
    chk("hit_count_disabled", hit_count, 0);
`endif

    // Conflict eviction at index 0.
    fetch(10'h080, 2);
    fetch(10'h000, 1);

    // Reset in the second MEM_READ cycle aborts the refill.
    read = 1'b1;
    address = 10'h040;
    next_lat = 5;
    exp_maddr_q.push_back(6'h04);
    @(negedge CLK);
    chk("abort_miss_busywait", busywait, 1);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("abort_mem_read_cycle1", mem_read, 1);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    read  = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    @(negedge CLK);
    chk("abort_mem_read", mem_read, 0);
    chk("abort_busywait", busywait, 0);
    @(posedge CLK);
    #1;
    fetch(10'h040, 2);

    // Read dropped during the refill of the top block.
    read = 1'b1;
    address = 10'h3FC;
    next_lat = 3;
    exp_maddr_q.push_back(6'h3F);
    @(posedge CLK);
    #1;
    read = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    mvalid[7] = 1'b1;
    mtag[7]   = 3'd7;
    fetch(10'h3FC, 1);

    // Random traffic over a few tags so hits, misses and evictions mix.
    for (int n = 0; n < 400; n++) begin
      ra = 10'($urandom());
      ra[9:7] = 3'($urandom_range(0, 2));
      fetch(ra, $urandom_range(1, 4));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge CLK);
        #1;
      end
    end

    @(negedge CLK);
    chk("instr_queue_drained", exp_instr_q.size(), 0);
    chk("maddr_queue_drained", exp_maddr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
